// File: rtl/fb_ctrl_pkg.sv
// Shared frame-buffer constants, freeze state encoding and write payload type
// for the write-side controller.
package fb_ctrl_pkg;

    localparam int unsigned FB_W    = 320;
    localparam int unsigned FB_H    = 240;
    localparam int unsigned FB_SIZE = FB_W * FB_H;
    localparam int unsigned ADDR_W  = 17;
    localparam int unsigned PIX_W   = 12;

    typedef enum logic [1:0] {
        RUN         = 2'd0,
        FREEZE_PEND = 2'd1,
        FROZEN      = 2'd2,
        RESUME_PEND = 2'd3
    } freeze_state_t;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [PIX_W-1:0]  data;
    } fb_wr_t;

    // True when the address lands inside the 320x240 buffer.
    function automatic logic addr_in_range(input logic [ADDR_W-1:0] addr);
        return addr < ADDR_W'(FB_SIZE);
    endfunction

endpackage

// File: rtl/fb_wr_fifo.sv
// Small synchronous FIFO of frame-buffer writes; a push into a full FIFO is
// accepted when a pop happens in the same cycle.
module fb_wr_fifo
    import fb_ctrl_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic   clk,
    input  logic   reset,
    input  logic   i_push,
    input  fb_wr_t i_wr,
    input  logic   i_pop,
    output fb_wr_t o_head_c,
    output logic   o_empty_c,
    output logic   o_full_c
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    fb_wr_t           r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    logic w_push;
    logic w_pop;

    assign o_empty_c = (r_count == '0);
    assign o_full_c  = (r_count == CNT_W'(DEPTH));
    assign o_head_c  = r_mem[r_rd_ptr];

    assign w_pop  = i_pop && !o_empty_c;
    assign w_push = i_push && (!o_full_c || w_pop);

    // Storage needs no reset: pointers define what is live.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_wr;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/fb_write_ctrl.sv
// Frame-buffer write port controller: arbitrates camera FIFO against overlay
// requests and applies freeze/resume only on frame boundaries.
module fb_write_ctrl
    import fb_ctrl_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH  = 4,
    parameter int unsigned OV_MAX_WAIT = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cam_valid,
    input  logic [ADDR_W-1:0] cam_addr,
    input  logic [PIX_W-1:0]  cam_data,
    input  logic              cam_vsync,
    input  logic              ov_req,
    input  logic [ADDR_W-1:0] ov_addr,
    input  logic [PIX_W-1:0]  ov_data,
    output logic              ov_gnt,
    input  logic              freeze,
    output logic              fb_we,
    output logic [ADDR_W-1:0] fb_wAddr,
    output logic [PIX_W-1:0]  fb_wData,
    output logic              frame_stop,
    output logic              cam_overflow,
    output logic              addr_err
);

    localparam int unsigned WAIT_W = (OV_MAX_WAIT > 0) ? $clog2(OV_MAX_WAIT + 1) : 1;

    freeze_state_t     r_state;
    freeze_state_t     w_state_nxt;
    logic [WAIT_W-1:0] r_wait;
    logic [WAIT_W-1:0] w_wait_nxt;

    logic              r_fb_we;
    logic [ADDR_W-1:0] r_fb_waddr;
    logic [PIX_W-1:0]  r_fb_wdata;
    logic              r_ov_gnt;
    logic              r_frame_stop;
    logic              r_cam_overflow;
    logic              r_addr_err;

    fb_wr_t w_cam_wr;
    fb_wr_t w_ov_wr;
    fb_wr_t w_head;
    fb_wr_t w_sel;
    logic   w_fifo_empty;
    logic   w_fifo_full;
    logic   w_ov_win;
    logic   w_pop;
    logic   w_sel_valid;
    logic   w_sel_ok;
    logic   w_cam_open;
    logic   w_push;
    logic   w_drop;

    fb_wr_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .i_push    (w_push),
        .i_wr      (w_cam_wr),
        .i_pop     (w_pop),
        .o_head_c  (w_head),
        .o_empty_c (w_fifo_empty),
        .o_full_c  (w_fifo_full)
    );

    // Arbitration, address check and camera accept for the current cycle.
    always_comb begin
        w_cam_wr.addr = cam_addr;
        w_cam_wr.data = cam_data;
        w_ov_wr.addr  = ov_addr;
        w_ov_wr.data  = ov_data;
        w_ov_win      = ov_req && (w_fifo_empty || (r_wait >= WAIT_W'(OV_MAX_WAIT)));
        w_pop         = !w_fifo_empty && !w_ov_win;
        w_sel         = w_ov_win ? w_ov_wr : w_head;
        w_sel_valid   = w_ov_win || w_pop;
        w_sel_ok      = addr_in_range(w_sel.addr);
        // Camera is judged against the pre-transition state.
        w_cam_open    = (r_state == RUN) || (r_state == FREEZE_PEND);
        w_push        = cam_valid && w_cam_open && (!w_fifo_full || w_pop);
        w_drop        = cam_valid && w_cam_open && w_fifo_full && !w_pop;
        w_wait_nxt    = (ov_req && !w_ov_win) ? r_wait + WAIT_W'(1) : '0;
    end

    // Freeze next-state: transitions into/out of FROZEN only on vsync.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            RUN: begin
                if (freeze) w_state_nxt = FREEZE_PEND;
            end
            FREEZE_PEND: begin
                if (!freeze)        w_state_nxt = RUN;
                else if (cam_vsync) w_state_nxt = FROZEN;
            end
            FROZEN: begin
                if (!freeze) w_state_nxt = RESUME_PEND;
            end
            RESUME_PEND: begin
                if (freeze)         w_state_nxt = FROZEN;
                else if (cam_vsync) w_state_nxt = RUN;
            end
            default: w_state_nxt = RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wait         <= '0;
            r_fb_we        <= 1'b0;
            r_fb_waddr     <= '0;
            r_fb_wdata     <= '0;
            r_ov_gnt       <= 1'b0;
            r_frame_stop   <= 1'b0;
            r_cam_overflow <= 1'b0;
            r_addr_err     <= 1'b0;
        end else begin
            r_wait       <= w_wait_nxt;
            r_fb_we      <= w_sel_valid && w_sel_ok;
            r_ov_gnt     <= w_ov_win;
            r_frame_stop <= (r_state == FROZEN) || (r_state == RESUME_PEND);
            if (w_sel_valid && w_sel_ok) begin
                r_fb_waddr <= w_sel.addr;
                r_fb_wdata <= w_sel.data;
            end
            if (w_drop) begin
                r_cam_overflow <= 1'b1;
            end
            if (w_sel_valid && !w_sel_ok) begin
                r_addr_err <= 1'b1;
            end
        end
    end

    assign fb_we        = r_fb_we;
    assign fb_wAddr     = r_fb_waddr;
    assign fb_wData     = r_fb_wdata;
    assign ov_gnt       = r_ov_gnt;
    assign frame_stop   = r_frame_stop;
    assign cam_overflow = r_cam_overflow;
    assign addr_err     = r_addr_err;

endmodule

// File: tb/tb_fb_write_ctrl.sv
// Bench for fb_write_ctrl: directed vector table, hand-written corner
// sequences and random traffic against a queue-based reference model.
module tb_fb_write_ctrl;
    import fb_ctrl_pkg::*;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned MAXW  = 8;
    localparam int          NV    = 25;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              cam_valid = 1'b0;
    logic [ADDR_W-1:0] cam_addr = '0;
    logic [PIX_W-1:0]  cam_data = '0;
    logic              cam_vsync = 1'b0;
    logic              ov_req = 1'b0;
    logic [ADDR_W-1:0] ov_addr = '0;
    logic [PIX_W-1:0]  ov_data = '0;
    logic              freeze = 1'b0;
    logic              ov_gnt;
    logic              fb_we;
    logic [ADDR_W-1:0] fb_wAddr;
    logic [PIX_W-1:0]  fb_wData;
    logic              frame_stop;
    logic              cam_overflow;
    logic              addr_err;

    always #5 clk = ~clk;

    fb_write_ctrl #(
        .FIFO_DEPTH  (DEPTH),
        .OV_MAX_WAIT (MAXW)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .cam_valid    (cam_valid),
        .cam_addr     (cam_addr),
        .cam_data     (cam_data),
        .cam_vsync    (cam_vsync),
        .ov_req       (ov_req),
        .ov_addr      (ov_addr),
        .ov_data      (ov_data),
        .ov_gnt       (ov_gnt),
        .freeze       (freeze),
        .fb_we        (fb_we),
        .fb_wAddr     (fb_wAddr),
        .fb_wData     (fb_wData),
        .frame_stop   (frame_stop),
        .cam_overflow (cam_overflow),
        .addr_err     (addr_err)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: pending camera pixels as a queue, image frozen/not plus
    // a "change requested" flag that only commits on vsync.
    fb_wr_t            m_q[$];
    int                m_wait;
    bit                m_frozen;
    bit                m_pend;
    bit                m_ovf;
    bit                m_aerr;
    bit                e_we;
    bit                e_gnt;
    bit                e_fs;
    logic [ADDR_W-1:0] e_addr;
    logic [PIX_W-1:0]  e_data;

    function automatic void model_step();
        fb_wr_t sel;
        bit     ov_win;
        bit     cam_win;
        if (reset) begin
            m_q.delete();
            m_wait   = 0;
            m_frozen = 1'b0;
            m_pend   = 1'b0;
            m_ovf    = 1'b0;
            m_aerr   = 1'b0;
            e_we     = 1'b0;
            e_gnt    = 1'b0;
            e_fs     = 1'b0;
            e_addr   = '0;
            e_data   = '0;
            return;
        end
        ov_win  = ov_req && (m_q.size() == 0 || m_wait >= int'(MAXW));
        cam_win = !ov_win && (m_q.size() != 0);
        e_gnt   = ov_win;
        e_we    = 1'b0;
        if (ov_win || cam_win) begin
            if (ov_win) begin
                sel.addr = ov_addr;
                sel.data = ov_data;
            end else begin
                sel = m_q.pop_front();
            end
            if (int'(sel.addr) < 76800) begin
                e_we   = 1'b1;
                e_addr = sel.addr;
                e_data = sel.data;
            end else begin
                m_aerr = 1'b1;
            end
        end
        m_wait = (ov_req && !ov_win) ? m_wait + 1 : 0;
        if (cam_valid && !m_frozen) begin
            if (m_q.size() < int'(DEPTH)) begin
                sel.addr = cam_addr;
                sel.data = cam_data;
                m_q.push_back(sel);
            end else begin
                m_ovf = 1'b1;
            end
        end
        e_fs = m_frozen;
        if (m_pend && cam_vsync && (freeze != m_frozen)) begin
            m_frozen = freeze;
            m_pend   = 1'b0;
        end else begin
            m_pend = (freeze != m_frozen);
        end
    endfunction

    task automatic run_cycle();
        model_step();
        @(posedge clk);
        #1;
        check("fb_we", 32'(fb_we), 32'(e_we));
        check("ov_gnt", 32'(ov_gnt), 32'(e_gnt));
        check("frame_stop", 32'(frame_stop), 32'(e_fs));
        check("cam_overflow", 32'(cam_overflow), 32'(m_ovf));
        check("addr_err", 32'(addr_err), 32'(m_aerr));
        if (e_we) begin
            check("fb_wAddr", 32'(fb_wAddr), 32'(e_addr));
            check("fb_wData", 32'(fb_wData), 32'(e_data));
        end
    endtask

    task automatic clear_inputs();
        reset     = 1'b0;
        cam_valid = 1'b0;
        cam_vsync = 1'b0;
        ov_req    = 1'b0;
    endtask

    typedef struct packed {
        logic              rst;
        logic              cv;
        logic [ADDR_W-1:0] ca;
        logic [PIX_W-1:0]  cd;
        logic              ovr;
        logic [ADDR_W-1:0] oa;
        logic [PIX_W-1:0]  od;
        logic              frz;
        logic              vs;
        logic              we;
        logic [ADDR_W-1:0] wa;
        logic [PIX_W-1:0]  wd;
        logic              gnt;
        logic              fs;
        logic              ovf;
        logic              aerr;
    } vec_t;

    vec_t vecs [NV];

    function automatic vec_t mkv(input logic rst, input logic cv, input int ca, input int cd,
                                 input logic ovr, input int oa, input int od,
                                 input logic frz, input logic vs,
                                 input logic we, input int wa, input int wd,
                                 input logic gnt, input logic fs, input logic ovf, input logic aerr);
        vec_t r;
        r.rst = rst;  r.cv = cv;  r.ca = ADDR_W'(ca); r.cd = PIX_W'(cd);
        r.ovr = ovr;  r.oa = ADDR_W'(oa); r.od = PIX_W'(od);
        r.frz = frz;  r.vs = vs;
        r.we  = we;   r.wa = ADDR_W'(wa); r.wd = PIX_W'(wd);
        r.gnt = gnt;  r.fs = fs;  r.ovf = ovf; r.aerr = aerr;
        return r;
    endfunction

    int cam_sent;
    int cam_seen;
    int gap;
    int max_gap;
    int cam_frozen;
    int ov_frozen;
    int cam_after;
    int stale;
    int guard;
    bit last_cam;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //            rst cv ca     cd     ovr oa     od     frz vs  we wa     wd     gnt fs ovf aerr
        vecs[0]  = mkv(1, 0, 0,     0,     0, 0,     0,     0, 0,  0, 0,     0,     0, 0, 0, 0);
        vecs[1]  = mkv(0, 1, 0,     'h111, 0, 0,     0,     0, 0,  0, 0,     0,     0, 0, 0, 0);
        vecs[2]  = mkv(0, 0, 0,     0,     0, 0,     0,     0, 0,  1, 0,     'h111, 0, 0, 0, 0);
        vecs[3]  = mkv(0, 1, 1,     'h222, 0, 0,     0,     0, 0,  0, 0,     0,     0, 0, 0, 0);
        vecs[4]  = mkv(0, 0, 0,     0,     0, 0,     0,     0, 0,  1, 1,     'h222, 0, 0, 0, 0);
        vecs[5]  = mkv(0, 1, 2,     'h333, 0, 0,     0,     0, 0,  0, 0,     0,     0, 0, 0, 0);
        vecs[6]  = mkv(0, 0, 0,     0,     0, 0,     0,     0, 0,  1, 2,     'h333, 0, 0, 0, 0);
        vecs[7]  = mkv(0, 0, 0,     0,     1, 5,     'hABC, 0, 0,  1, 5,     'hABC, 1, 0, 0, 0);
        vecs[8]  = mkv(0, 0, 0,     0,     1, 76800, 0,     0, 0,  0, 0,     0,     1, 0, 0, 1);
        vecs[9]  = mkv(0, 0, 0,     0,     0, 0,     0,     0, 0,  0, 0,     0,     0, 0, 0, 1);
        vecs[10] = mkv(0, 1, 76801, 7,     0, 0,     0,     0, 0,  0, 0,     0,     0, 0, 0, 1);
        vecs[11] = mkv(0, 0, 0,     0,     0, 0,     0,     0, 0,  0, 0,     0,     0, 0, 0, 1);
        vecs[12] = mkv(0, 1, 76799, 'hFFF, 0, 0,     0,     0, 0,  0, 0,     0,     0, 0, 0, 1);
        vecs[13] = mkv(0, 0, 0,     0,     0, 0,     0,     0, 0,  1, 76799, 'hFFF, 0, 0, 0, 1);
        vecs[14] = mkv(0, 1, 10,    1,     1, 20,    2,     0, 0,  1, 20,    2,     1, 0, 0, 1);
        vecs[15] = mkv(0, 0, 0,     0,     0, 0,     0,     0, 0,  1, 10,    1,     0, 0, 0, 1);
        vecs[16] = mkv(0, 1, 11,    3,     0, 0,     0,     0, 0,  0, 0,     0,     0, 0, 0, 1);
        vecs[17] = mkv(0, 0, 0,     0,     1, 21,    4,     0, 0,  1, 11,    3,     0, 0, 0, 1);
        vecs[18] = mkv(0, 0, 0,     0,     1, 21,    4,     0, 0,  1, 21,    4,     1, 0, 0, 1);
        vecs[19] = mkv(0, 0, 0,     0,     0, 0,     0,     1, 0,  0, 0,     0,     0, 0, 0, 1);
        vecs[20] = mkv(0, 0, 0,     0,     0, 0,     0,     1, 1,  0, 0,     0,     0, 0, 0, 1);
        vecs[21] = mkv(0, 1, 30,    5,     0, 0,     0,     1, 0,  0, 0,     0,     0, 1, 0, 1);
        vecs[22] = mkv(0, 0, 0,     0,     0, 0,     0,     0, 0,  0, 0,     0,     0, 1, 0, 1);
        vecs[23] = mkv(0, 0, 0,     0,     0, 0,     0,     0, 1,  0, 0,     0,     0, 1, 0, 1);
        vecs[24] = mkv(0, 0, 0,     0,     0, 0,     0,     0, 0,  0, 0,     0,     0, 0, 0, 1);

        for (int i = 0; i < NV; i++) begin
            reset     = vecs[i].rst;
            cam_valid = vecs[i].cv;
            cam_addr  = vecs[i].ca;
            cam_data  = vecs[i].cd;
            ov_req    = vecs[i].ovr;
            ov_addr   = vecs[i].oa;
            ov_data   = vecs[i].od;
            freeze    = vecs[i].frz;
            cam_vsync = vecs[i].vs;
            @(posedge clk);
            #1;
            check($sformatf("vec%0d fb_we", i), 32'(fb_we), 32'(vecs[i].we));
            check($sformatf("vec%0d ov_gnt", i), 32'(ov_gnt), 32'(vecs[i].gnt));
            check($sformatf("vec%0d frame_stop", i), 32'(frame_stop), 32'(vecs[i].fs));
            check($sformatf("vec%0d cam_overflow", i), 32'(cam_overflow), 32'(vecs[i].ovf));
            check($sformatf("vec%0d addr_err", i), 32'(addr_err), 32'(vecs[i].aerr));
            if (vecs[i].we) begin
                check($sformatf("vec%0d fb_wAddr", i), 32'(fb_wAddr), 32'(vecs[i].wa));
                check($sformatf("vec%0d fb_wData", i), 32'(fb_wData), 32'(vecs[i].wd));
            end
        end
        clear_inputs();
        freeze = 1'b0;

        // Continuous overlay against camera every 2 clocks.
        reset = 1'b1; run_cycle(); reset = 1'b0;
        cam_sent = 0; cam_seen = 0; gap = 0; max_gap = 0;
        for (int c = 0; c < 40; c++) begin
            cam_valid = (c % 2 == 0);
            cam_addr  = ADDR_W'(1000 + c);
            cam_data  = PIX_W'(c);
            ov_req    = 1'b1;
            ov_addr   = ADDR_W'(100);
            ov_data   = 12'hF00;
            if (cam_valid) cam_sent++;
            run_cycle();
            if (ov_gnt) gap = 0; else gap++;
            if (gap > max_gap) max_gap = gap;
            if (fb_we && fb_wAddr != ADDR_W'(100)) cam_seen++;
        end
        clear_inputs();
        for (int c = 0; c < 4; c++) begin
            run_cycle();
            if (fb_we && fb_wAddr != ADDR_W'(100)) cam_seen++;
        end
        check("overlay blocked cycles within limit", 32'(max_gap <= int'(MAXW)), 32'd1);
        check("camera pixels written under overlay load", 32'(cam_seen), 32'(cam_sent));
        check("no overflow at half rate", 32'(cam_overflow), 32'd0);

        // Full-rate camera plus held overlay eventually overflows the FIFO.
        reset = 1'b1; run_cycle(); reset = 1'b0;
        for (int c = 0; c < 48; c++) begin
            cam_valid = 1'b1;
            cam_addr  = ADDR_W'(2000 + c);
            cam_data  = PIX_W'(c + 7);
            ov_req    = 1'b1;
            ov_addr   = ADDR_W'(100);
            ov_data   = 12'hF00;
            run_cycle();
        end
        clear_inputs();
        for (int c = 0; c < 8; c++) run_cycle();
        check("overflow sticky after drops", 32'(cam_overflow), 32'd1);

        // Freeze on frame boundary, overlay still lands, resume on next vsync.
        reset = 1'b1; run_cycle(); reset = 1'b0;
        cam_frozen = 0; ov_frozen = 0; cam_after = 0;
        for (int c = 0; c < 80; c++) begin
            cam_valid = (c % 2 == 0);
            cam_addr  = ADDR_W'(3000 + c);
            cam_data  = PIX_W'(c);
            ov_req    = (c % 7 == 3) && (c >= 23) && (c <= 53);
            ov_addr   = ADDR_W'(60000 + c);
            ov_data   = PIX_W'(c + 1);
            freeze    = (c >= 10) && (c < 45);
            cam_vsync = (c == 20) || (c == 55);
            run_cycle();
            if (fb_we && fb_wAddr < ADDR_W'(60000)) begin
                if (c >= 23 && c <= 55) cam_frozen++;
                if (c >= 58) cam_after++;
            end
            if (fb_we && fb_wAddr >= ADDR_W'(60000) && c >= 23 && c <= 55) ov_frozen++;
        end
        clear_inputs();
        freeze = 1'b0;
        check("no camera writes while frozen", 32'(cam_frozen), 32'd0);
        check("overlay writes while frozen", 32'(ov_frozen > 0), 32'd1);
        check("camera writes after resume", 32'(cam_after > 0), 32'd1);

        // Reset with entries queued: everything clears, stale pixels never land.
        reset = 1'b1; run_cycle(); reset = 1'b0;
        guard = 0;
        while (m_q.size() < 3 && guard < 60) begin
            cam_valid = 1'b1;
            cam_addr  = ADDR_W'(4000 + guard);
            cam_data  = PIX_W'(guard);
            ov_req    = 1'b1;
            ov_addr   = (guard == 0) ? ADDR_W'(90000) : ADDR_W'(100);
            ov_data   = 12'h0F0;
            run_cycle();
            guard++;
        end
        clear_inputs();
        reset = 1'b1;
        run_cycle();
        reset = 1'b0;
        check("flags after reset", 32'({fb_we, ov_gnt, frame_stop, cam_overflow, addr_err}), 32'd0);
        check("fb_wAddr after reset", 32'(fb_wAddr), 32'd0);
        check("fb_wData after reset", 32'(fb_wData), 32'd0);
        stale = 0;
        for (int c = 0; c < 8; c++) begin
            run_cycle();
            if (fb_we) stale++;
        end
        check("stale writes after reset", 32'(stale), 32'd0);

        // Random traffic against the model.
        reset = 1'b1; run_cycle(); reset = 1'b0;
        last_cam = 1'b0;
        for (int c = 0; c < 2500; c++) begin
            reset     = ($urandom_range(0, 499) == 0);
            cam_valid = last_cam ? ($urandom_range(0, 9) == 0) : ($urandom_range(0, 1) == 1);
            last_cam  = cam_valid;
            cam_addr  = ($urandom_range(0, 15) == 0) ? ADDR_W'($urandom_range(76800, 131071))
                                                      : ADDR_W'($urandom_range(0, 76799));
            cam_data  = PIX_W'($urandom);
            cam_vsync = ($urandom_range(0, 24) == 0);
            if ($urandom_range(0, 59) == 0) freeze = ~freeze;
            if (!ov_req || e_gnt) begin
                ov_req  = ($urandom_range(0, 3) == 0);
                ov_addr = ($urandom_range(0, 15) == 0) ? ADDR_W'($urandom_range(76800, 131071))
                                                        : ADDR_W'($urandom_range(0, 76799));
                ov_data = PIX_W'($urandom);
            end
            run_cycle();
        end
        clear_inputs();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
